// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: register hazards against the E/M producers,
// multiply/divide busy window, PC/FD enables, DE bubble and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       Tuse_Rs_D,
    input  logic [1:0]       Tuse_Rt_D,
    input  logic             md_use_D,
    input  logic [4:0]       A3_E,
    input  logic [1:0]       Tnew_E,
    input  logic [4:0]       A3_M,
    input  logic [1:0]       Tnew_M,
    input  logic             md_start_E,
    input  logic             md_div_E,
    output logic             en_PC,
    output logic             en_FD,
    output logic             flush_DE,
    output logic             stall,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

    localparam logic [3:0]       MultLen = 4'(MULT_CYC);
    localparam logic [3:0]       DivLen  = 4'(DIV_CYC);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    md_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hz_e, hz_m, hz_md, stall_raw;

    // Same-cycle hazard detection; register $0 is never a real dependence.
    always_comb begin
        hz_e = (A3_E != 5'd0) &&
               (((A3_E == rs_D) && (Tuse_Rs_D < Tnew_E)) ||
                ((A3_E == rt_D) && (Tuse_Rt_D < Tnew_E)));
        hz_m = (A3_M != 5'd0) &&
               (((A3_M == rs_D) && (Tuse_Rs_D < Tnew_M)) ||
                ((A3_M == rt_D) && (Tuse_Rt_D < Tnew_M)));
        // A start in E this cycle already blocks a dependent MDU instruction in D.
        hz_md = md_use_D && ((state_q == StBusy) || md_start_E);
        stall_raw = hz_e || hz_m || hz_md;
    end

    // MDU state and countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MDU next state: a new start always reloads the window, even while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (md_start_E) begin
            state_d = StBusy;
            cnt_d   = md_div_E ? DivLen : MultLen;
        end else if (state_q == StBusy) begin
            if (cnt_q == 4'd1) begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Control outputs; reset forces the pipeline to run without bubbles.
    always_comb begin
        stall     = stall_raw && !reset;
        en_PC     = !stall;
        en_FD     = !stall;
        flush_DE  = stall;
        md_busy   = (state_q == StBusy);
        stall_cnt = stall_cnt_q;
    end

    // Stall counter next value, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vectors, MDU sequences and
// randomized traffic compared against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs_D, rt_D, A3_E, A3_M;
    logic [1:0]    Tuse_Rs_D, Tuse_Rt_D, Tnew_E, Tnew_M;
    logic          md_use_D, md_start_E, md_div_E;
    logic          en_PC, en_FD, flush_DE, stall, md_busy;
    logic [CW-1:0] stall_cnt;

    int n_chk     = 0;
    int n_err     = 0;
    int busy_left = 0;
    int cnt_ref   = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3e;
        logic [1:0] tnewe;
        logic [4:0] a3m;
        logic [1:0] tnewm;
        logic       exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MULT_CYC(5),
        .DIV_CYC (10),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .Tuse_Rs_D (Tuse_Rs_D),
        .Tuse_Rt_D (Tuse_Rt_D),
        .md_use_D  (md_use_D),
        .A3_E      (A3_E),
        .Tnew_E    (Tnew_E),
        .A3_M      (A3_M),
        .Tnew_M    (Tnew_M),
        .md_start_E(md_start_E),
        .md_div_E  (md_div_E),
        .en_PC     (en_PC),
        .en_FD     (en_FD),
        .flush_DE  (flush_DE),
        .stall     (stall),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a stage producer blocks a source when it will be ready later than needed.
    function automatic bit ref_stall();
        logic [4:0] a3[2];
        logic [1:0] tn[2];
        bit         h;
        if (reset) return 1'b0;
        a3[0] = A3_E;  a3[1] = A3_M;
        tn[0] = Tnew_E; tn[1] = Tnew_M;
        h = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (a3[p] != 5'd0) begin
                if (a3[p] == rs_D && int'(Tuse_Rs_D) < int'(tn[p])) h = 1'b1;
                if (a3[p] == rt_D && int'(Tuse_Rt_D) < int'(tn[p])) h = 1'b1;
            end
        end
        if (md_use_D && (busy_left > 0 || md_start_E)) h = 1'b1;
        return h;
    endfunction

    // Check every output at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit s;
        @(negedge clk);
        s = ref_stall();
        chk("stall", 32'(stall), 32'(s));
        chk("en_PC", 32'(en_PC), 32'(!s));
        chk("en_FD", 32'(en_FD), 32'(!s));
        chk("flush_DE", 32'(flush_DE), 32'(s));
        chk("md_busy", 32'(md_busy), 32'(busy_left > 0));
        chk("stall_cnt", 32'(stall_cnt), 32'(cnt_ref));
        @(posedge clk);
        if (reset) begin
            busy_left = 0;
            cnt_ref   = 0;
        end else begin
            if (md_start_E) busy_left = md_div_E ? 10 : 5;
            else if (busy_left > 0) busy_left--;
            if (s && cnt_ref < CNT_MAX) cnt_ref++;
        end
        #1;
    endtask

    task automatic clear();
        rs_D = 5'd0; rt_D = 5'd0; Tuse_Rs_D = 2'd3; Tuse_Rt_D = 2'd3;
        A3_E = 5'd0; Tnew_E = 2'd0; A3_M = 5'd0; Tnew_M = 2'd0;
        md_use_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'd5,  5'd0, 2'd1, 2'd3, 5'd5,  2'd2, 5'd0, 2'd0, 1'b1};
        vecs[1]  = '{5'd5,  5'd0, 2'd1, 2'd3, 5'd0,  2'd0, 5'd5, 2'd1, 1'b0};
        vecs[2]  = '{5'd0,  5'd0, 2'd0, 2'd3, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[3]  = '{5'd0,  5'd7, 2'd3, 2'd3, 5'd7,  2'd2, 5'd0, 2'd0, 1'b0};
        vecs[4]  = '{5'd0,  5'd7, 2'd3, 2'd0, 5'd7,  2'd1, 5'd0, 2'd0, 1'b1};
        vecs[5]  = '{5'd3,  5'd0, 2'd0, 2'd3, 5'd0,  2'd0, 5'd3, 2'd1, 1'b1};
        vecs[6]  = '{5'd3,  5'd0, 2'd1, 2'd3, 5'd0,  2'd0, 5'd3, 2'd1, 1'b0};
        vecs[7]  = '{5'd9,  5'd0, 2'd0, 2'd3, 5'd10, 2'd2, 5'd0, 2'd0, 1'b0};
        vecs[8]  = '{5'd0,  5'd0, 2'd0, 2'd0, 5'd0,  2'd2, 5'd0, 2'd2, 1'b0};
        vecs[9]  = '{5'd31, 5'd0, 2'd0, 2'd3, 5'd31, 2'd0, 5'd0, 2'd0, 1'b0};
        vecs[10] = '{5'd4,  5'd4, 2'd3, 2'd1, 5'd4,  2'd2, 5'd0, 2'd0, 1'b1};

        // Reset state
        clear();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_en_PC", 32'(en_PC), 32'd1);
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;

        // Directed register-hazard vectors
        foreach (vecs[i]) begin
            clear();
            rs_D = vecs[i].rs; rt_D = vecs[i].rt;
            Tuse_Rs_D = vecs[i].tuse_rs; Tuse_Rt_D = vecs[i].tuse_rt;
            A3_E = vecs[i].a3e; Tnew_E = vecs[i].tnewe;
            A3_M = vecs[i].a3m; Tnew_M = vecs[i].tnewm;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_en_PC", i), 32'(en_PC), 32'(!vecs[i].exp));
            chk($sformatf("vec%0d_flush", i), 32'(flush_DE), 32'(vecs[i].exp));
            step();
        end

        // Multiply window with a dependent MDU instruction waiting in D
        clear();
        md_use_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b0;
        #1;
        chk("same_cycle_stall", 32'(stall), 32'd1);
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("mult_busy", 32'(md_busy), 32'(i < 5));
            chk("mult_stall", 32'(stall), 32'(i < 5));
            step();
        end

        // Divide window
        md_use_D = 1'b0; md_start_E = 1'b1; md_div_E = 1'b1;
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("div_busy", 32'(md_busy), 32'(i < 10));
            step();
        end

        // Restart: a div issued while a mult is still busy reloads the window
        md_start_E = 1'b1; md_div_E = 1'b0;
        step();
        md_start_E = 1'b0;
        repeat (2) step();
        md_start_E = 1'b1; md_div_E = 1'b1;
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("restart_busy", 32'(md_busy), 32'(i < 10));
            step();
        end

        // Reset during busy cycle 4 of a divide, then a start coinciding with reset
        md_use_D = 1'b1; md_start_E = 1'b1; md_div_E = 1'b1;
        step();
        md_start_E = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("rst_mid_en_PC", 32'(en_PC), 32'd1);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        step();
        chk("rst_mid_busy", 32'(md_busy), 32'd0);
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
        md_start_E = 1'b1;
        step();
        chk("rst_start_discard", 32'(md_busy), 32'd0);
        reset = 1'b0;
        clear();
        step();

        // Saturation: hold a load-use stall for 20 cycles
        rs_D = 5'd5; Tuse_Rs_D = 2'd1; A3_E = 5'd5; Tnew_E = 2'd2;
        repeat (20) step();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        clear();
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            rs_D       = 5'($urandom_range(0, 3));
            rt_D       = 5'($urandom_range(0, 3));
            Tuse_Rs_D  = 2'($urandom_range(0, 3));
            Tuse_Rt_D  = 2'($urandom_range(0, 3));
            A3_E       = 5'($urandom_range(0, 3));
            Tnew_E     = 2'($urandom_range(0, 2));
            A3_M       = 5'($urandom_range(0, 3));
            Tnew_M     = 2'($urandom_range(0, 2));
            md_use_D   = ($urandom_range(0, 2) == 0);
            md_start_E = ($urandom_range(0, 7) == 0);
            md_div_E   = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
